// File: rtl/downstream_order_tracker_pkg.sv
// rtl/downstream_order_tracker_pkg.sv - shared widths, order payload type and saturating add
package downstream_pkg;

    localparam int CLIENT_W = 5;
    localparam int AMT_W    = 16;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic [4:0]  client;
        logic [15:0] amount;
    } order_t;

    function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                                 input logic [AMT_W-1:0] b);
        logic [AMT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[AMT_W] ? {AMT_W{1'b1}} : s[AMT_W-1:0];
    endfunction

endpackage

// File: rtl/downstream_order_tracker_if.sv
// rtl/downstream_order_tracker_if.sv - order, exchange, cancel and query signal bundle
interface downstream_order_tracker_if;
    import downstream_pkg::*;

    logic                ord_valid;
    logic                ord_ready;
    logic [CLIENT_W-1:0] ord_client;
    logic [AMT_W-1:0]    ord_amount;

    logic                tx_valid;
    logic                tx_ready;
    logic [CLIENT_W-1:0] tx_client;
    logic [AMT_W-1:0]    tx_amount;

    logic                cxl_valid;
    logic [CLIENT_W-1:0] cxl_client;
    logic [AMT_W-1:0]    cxl_amount;
    logic                cxl_err;

    logic [CLIENT_W-1:0] q_client;
    logic [AMT_W-1:0]    cancelled_orders;
    logic [CNT_W-1:0]    fifo_count;

    modport master (
        output ord_valid, ord_client, ord_amount,
        output tx_ready,
        output cxl_valid, cxl_client, cxl_amount,
        output q_client,
        input  ord_ready, tx_valid, tx_client, tx_amount,
        input  cxl_err, cancelled_orders, fifo_count
    );

    modport slave (
        input  ord_valid, ord_client, ord_amount,
        input  tx_ready,
        input  cxl_valid, cxl_client, cxl_amount,
        input  q_client,
        output ord_ready, tx_valid, tx_client, tx_amount,
        output cxl_err, cancelled_orders, fifo_count
    );

endinterface

// File: rtl/downstream_order_tracker_fifo.sv
// rtl/downstream_order_tracker_fifo.sv - first-word fall-through FIFO, flags derived from count
module order_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Push is gated by the registered full flag, so a pop never frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? T'('0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/downstream_order_tracker.sv
// rtl/downstream_order_tracker.sv - order FIFO toward the exchange plus per-client sent/cancelled totals
module downstream_order_tracker
    import downstream_pkg::order_t, downstream_pkg::sat_add;
#(
    parameter int CLIENTS = 32,
    parameter int AMT_W   = 16,
    parameter int DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    downstream_order_tracker_if.slave     bus
);
    order_t           ord_in;
    order_t           head;
    logic             full;
    logic             empty;
    logic             pop;

    logic [AMT_W-1:0] sent_total      [CLIENTS];
    logic [AMT_W-1:0] cancelled_total [CLIENTS];

    logic [AMT_W:0]   cxl_sum;
    logic             cxl_ok;
    logic             cxl_accept;
    logic [AMT_W-1:0] q_next;

    assign ord_in.client = bus.ord_client;
    assign ord_in.amount = bus.ord_amount;

    order_fifo #(
        .DEPTH (DEPTH),
        .T     (order_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ord_valid),
        .pop   (bus.tx_ready),
        .din   (ord_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.fifo_count)
    );

    assign bus.ord_ready = !full;
    assign bus.tx_valid  = !empty;
    assign bus.tx_client = head.client;
    assign bus.tx_amount = head.amount;
    assign pop           = !empty && bus.tx_ready;

    // Checked against pre-edge totals, so a same-cycle pop for the client does not count yet.
    always_comb begin
        cxl_sum    = {1'b0, cancelled_total[bus.cxl_client]} + {1'b0, bus.cxl_amount};
        cxl_ok     = (cxl_sum <= {1'b0, sent_total[bus.cxl_client]});
        cxl_accept = bus.cxl_valid && cxl_ok;
        q_next     = cancelled_total[bus.q_client];
        if (cxl_accept && (bus.cxl_client == bus.q_client)) begin
            q_next = cxl_sum[AMT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLIENTS; i++) begin
                sent_total[i]      <= '0;
                cancelled_total[i] <= '0;
            end
            bus.cxl_err          <= 1'b0;
            bus.cancelled_orders <= '0;
        end else begin
            if (pop) begin
                sent_total[head.client] <= sat_add(sent_total[head.client], head.amount);
            end
            if (cxl_accept) begin
                cancelled_total[bus.cxl_client] <= cxl_sum[AMT_W-1:0];
            end
            bus.cxl_err          <= bus.cxl_valid && !cxl_ok;
            bus.cancelled_orders <= q_next;
        end
    end

endmodule

// File: doc/downstream_order_tracker.md
# downstream_order_tracker

Downstream neighbour of the upstream risk processor. It accepts risk-approved orders, buffers them in an 8-deep FIFO toward the exchange-side interface, and keeps per-client running totals of sent and cancelled amounts. It validates incoming cancel notifications against those totals. Its `cancelled_orders` output is the per-client cancelled total that the upstream stage subtracts in its risk check.

## Interface
Parameters:
- `CLIENTS`, 32 — number of tracked clients; client ids are `$clog2(CLIENTS)` = 5 bits.
- `AMT_W`, 16 — width of amounts and totals.
- `DEPTH`, 8 — order FIFO depth; must be a power of two.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `ord_valid`  in  1  — approved order offered by the upstream stage.
- `ord_ready`  out  1  — FIFO not full.
- `ord_client`  in  5  — client id of the offered order.
- `ord_amount`  in  16  — amount of the offered order.
- `tx_valid`  out  1  — FIFO head is valid.
- `tx_ready`  in  1  — exchange side accepts the head.
- `tx_client`  out  5  — client id of the FIFO head.
- `tx_amount`  out  16  — amount of the FIFO head.
- `cxl_valid`  in  1  — single-cycle cancel notification.
- `cxl_client`  in  5  — client id of the cancel.
- `cxl_amount`  in  16  — amount being cancelled.
- `cxl_err`  out  1  — one-cycle pulse when a cancel is rejected.
- `q_client`  in  5  — query index driven by the upstream stage.
- `cancelled_orders`  out  16  — registered cancelled total for `q_client`.
- `fifo_count`  out  4  — FIFO occupancy, 0..8.

## Operation
- **Push:** `ord_valid && ord_ready` writes {client, amount} at the tail.
- **Pop:** `tx_valid && tx_ready` removes the head and updates the sender total: `sent_total[tx_client] += tx_amount`, saturating at 0xFFFF.
- **FIFO flags:** `ord_ready = (fifo_count != DEPTH)`; `tx_valid = (fifo_count != 0)`.
  - Pointers are 3 bits and wrap from 7 to 0; full/empty come from the count, not from pointer compare.
  - A simultaneous push and pop leaves the count unchanged; this is legal only when not full and not empty.
- **Cancel check:** a cancel is accepted iff `cancelled_total[c] + cxl_amount <= sent_total[c]`.
  - The sum is computed at 17 bits.
  - The check uses pre-edge register values.
  - Accepted: `cancelled_total[c] += cxl_amount`.
  - Rejected: no update; `cxl_err` is high for exactly the next cycle.
- **Same client, same cycle (pop and cancel):** the cancel check sees the old `sent_total`; both updates apply at the same edge.
- **cxl_amount = 0:** always accepted; totals are unchanged.
- **Query output:** `cancelled_orders` registers the post-update value of `cancelled_total[q_client]`. A cancel accepted at edge n for the queried client is therefore visible after edge n, with no stale cycle.
- **Reset (asynchronous, any time, including mid-transfer):**
  - The FIFO empties.
  - All totals are cleared.
  - `tx_valid=0`, `ord_ready=1`, `cxl_err=0`, `cancelled_orders=0`, `fifo_count=0`, `tx_client=0`, `tx_amount=0`.
  - An in-flight head is discarded and not counted as sent.

## Timing
- **Push to head:** an order pushed into an empty FIFO at edge n gives `tx_valid=1`, with its data on `tx_client`/`tx_amount`, after edge n (1-cycle latency). The FIFO is first-word fall-through.
- **Head stability:** the head holds stable while `tx_valid && !tx_ready`.
- **Query latency:** `q_client` change to `cancelled_orders` is 1 cycle.
- **Cancel error:** `cxl_valid` at edge n gives `cxl_err` during cycle n+1 only.
- **Backpressure:** no combinational path from `tx_ready` to `ord_ready`. While full, a pop does not free a slot for a same-cycle push.

## Structure
- **Package `downstream_pkg`:**
  - `CLIENT_W=5`, `AMT_W=16`.
  - `typedef struct packed {logic [4:0] client; logic [15:0] amount;} order_t;`.
- **Sub-module `order_fifo`:**
  - Parameterised on `DEPTH` and payload type.
  - Ports: push/pop, `full`/`empty`, `count`.
- **Top level:** holds the two 32×16 total arrays, the cancel-check logic and the query register.

## Test plan
1. Reset, then push {3, 100} with `tx_ready=0` → `tx_valid=1` next cycle, `tx_client=3`, `tx_amount=100`, `fifo_count=1`. Raise `tx_ready` → `fifo_count=0` and `sent_total[3]=100`.
2. Push 8 orders with `tx_ready=0` → `ord_ready=0` and `fifo_count=8`; a 9th `ord_valid` is ignored. Drain → all 8 emerge in push order, with the pointers wrapping.
3. `sent_total[5]=50`; cancel {5, 30}, then cancel {5, 30} → the first is accepted, `cancelled_orders=30` with `q_client=5`. The second is rejected: `cxl_err` pulses once and the total stays 30.
4. Sent totals: 0xFFF0 + 0x0100 for one client → `sent_total` saturates at 0xFFFF; a cancel of 0xFFFF is then accepted.
5. Same-cycle pop {7, 40} and cancel {7, 40} with `sent_total[7]=0` → the cancel is rejected (pre-edge values), `cxl_err=1`, `sent_total[7]=40`.
6. Assert `rst` mid-drain with 4 entries → all outputs reach their reset values immediately. After release, `cancelled_orders=0` for every `q_client`.
